// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path (and the later TX path).
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP,
        WAIT_HI
    } rx_state_e;

    // Each FIFO entry carries {break, parity_err, frame_err} on top of the payload.
    localparam int FLAG_BITS = 3;

    function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
        int den;
        int d;
        den = baud * oversample;
        d   = (clk_freq + den / 2) / den;
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered count; a push into a full FIFO is only
// accepted when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (!do_push && do_pop)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with majority vote, error/break flags, receive
// FIFO, sticky overrun and active-low clear-to-send flow control.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 25000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int CTS_MARGIN = 1
) (
    input  logic                 clk25,
    input  logic                 rst_n,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_break,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 overrun,
    input  logic                 status_clr,
    output logic                 uart_cts
);
    localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int TW  = $clog2(DIV + 1);
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int EW  = DATA_BITS + FLAG_BITS;
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam parity_e PMODE = parity_e'(PARITY);
    localparam logic [SW-1:0] S_LO   = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_HI   = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [3:0]    LAST_BIT = 4'(DATA_BITS - 1);

    rx_state_e            state, state_next;
    logic                 rx_meta, rx_sync, rx_prev;
    logic [TW-1:0]        tick_cnt;
    logic                 tick;
    logic [SW-1:0]        samp_cnt;
    logic                 s_lo, s_mid;
    logic [3:0]           bit_cnt;
    logic                 stop_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 par_bit, par_err, frame_err;
    logic                 vote, decide, bit_end, last_stop, frame_err_now, brk;
    logic                 push, pop, drop, full, empty;
    logic [EW-1:0]        push_entry, head;
    logic [CW-1:0]        count;
    logic                 overrun_q, cts_q;

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n)
            tick_cnt <= '0;
        else if (state == IDLE || tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + 1'b1;
    end

    assign tick = (state != IDLE) && (tick_cnt == TW'(DIV - 1));

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Bit decisions are taken on the third vote sample, when all three are known.
    always_comb begin
        vote          = (s_lo & s_mid) | (s_lo & rx_sync) | (s_mid & rx_sync);
        decide        = tick && (samp_cnt == S_HI);
        bit_end       = tick && (samp_cnt == S_LAST);
        last_stop     = (STOP_BITS == 1) ? 1'b1 : stop_cnt;
        frame_err_now = frame_err | ~vote;
        brk           = frame_err_now && (shift == '0) && ((PMODE == PAR_NONE) || !par_bit);
        push          = 1'b0;
        state_next    = state;
        case (state)
            IDLE:    if (rx_prev && !rx_sync) state_next = START;
            START: begin
                if (decide && vote)  state_next = IDLE;
                else if (bit_end)    state_next = DATA;
            end
            DATA:    if (bit_end && bit_cnt == LAST_BIT)
                         state_next = (PMODE != PAR_NONE) ? PAR : STOP;
            PAR:     if (bit_end) state_next = STOP;
            STOP:    if (decide && last_stop) begin
                         push       = 1'b1;
                         state_next = vote ? IDLE : WAIT_HI;
                     end
            WAIT_HI: if (rx_sync) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            samp_cnt  <= '0;
            s_lo      <= 1'b1;
            s_mid     <= 1'b1;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            shift     <= '0;
            par_bit   <= 1'b0;
            par_err   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (state == IDLE)
                samp_cnt <= '0;
            else if (tick)
                samp_cnt <= (samp_cnt == S_LAST) ? '0 : samp_cnt + 1'b1;
            if (tick && samp_cnt == S_LO)  s_lo  <= rx_sync;
            if (tick && samp_cnt == S_MID) s_mid <= rx_sync;
            case (state)
                START: begin
                    bit_cnt   <= '0;
                    stop_cnt  <= 1'b0;
                    par_bit   <= 1'b0;
                    par_err   <= 1'b0;
                    frame_err <= 1'b0;
                end
                DATA: begin
                    if (decide)  shift   <= {vote, shift[DATA_BITS-1:1]};
                    if (bit_end) bit_cnt <= bit_cnt + 1'b1;
                end
                PAR: if (decide) begin
                    par_bit <= vote;
                    par_err <= (^shift) ^ vote ^ (PMODE == PAR_ODD);
                end
                STOP: begin
                    if (decide)  frame_err <= frame_err_now;
                    if (bit_end) stop_cnt  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign push_entry = {brk, par_err, frame_err_now, shift};
    assign pop        = !empty && rx_ready;
    assign drop       = push && full && !pop;

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk25),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .wr_data (push_entry),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= 1'b0;
            cts_q     <= 1'b1;
        end else begin
            if (drop)            overrun_q <= 1'b1;
            else if (status_clr) overrun_q <= 1'b0;
            cts_q <= ((FIFO_DEPTH - int'(count)) <= CTS_MARGIN);
        end
    end

    assign rx_valid = !empty;
    assign {rx_break, rx_parity_err, rx_frame_err, rx_data} = rx_valid ? head : '0;
    assign overrun  = overrun_q;
    assign uart_cts = cts_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: an 8N1 instance and a 7E1 instance at
// one bit per 16 clk25 cycles.
module tb_uart_rx_fifo;

    typedef struct packed {
        logic       brk;
        logic       pe;
        logic       fe;
        logic [8:0] data;
    } ent_t;

    logic       clk25 = 1'b0;
    logic       rst_n;
    logic       line8, ready8, clr8;
    logic       line7, ready7, clr7;
    logic [7:0] data8;
    logic [6:0] data7;
    logic       fe8, pe8, brk8, valid8, overrun8, cts8;
    logic       fe7, pe7, brk7, valid7, overrun7, cts7;

    ent_t q8[$];
    ent_t q7[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #20 clk25 = ~clk25;

    uart_rx_fifo #(
        .CLK_FREQ(25000000), .BAUD(1562500), .OVERSAMPLE(16), .DATA_BITS(8),
        .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4), .CTS_MARGIN(1)
    ) dut8 (
        .clk25(clk25), .rst_n(rst_n), .uart_rx(line8), .rx_data(data8),
        .rx_frame_err(fe8), .rx_parity_err(pe8), .rx_break(brk8), .rx_valid(valid8),
        .rx_ready(ready8), .overrun(overrun8), .status_clr(clr8), .uart_cts(cts8)
    );

    uart_rx_fifo #(
        .CLK_FREQ(25000000), .BAUD(1562500), .OVERSAMPLE(16), .DATA_BITS(7),
        .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4), .CTS_MARGIN(1)
    ) dut7 (
        .clk25(clk25), .rst_n(rst_n), .uart_rx(line7), .rx_data(data7),
        .rx_frame_err(fe7), .rx_parity_err(pe7), .rx_break(brk7), .rx_valid(valid7),
        .rx_ready(ready7), .overrun(overrun7), .status_clr(clr7), .uart_cts(cts7)
    );

    function automatic ent_t mk(input logic b, input logic p, input logic f, input logic [8:0] d);
        ent_t e;
        e.brk  = b;
        e.pe   = p;
        e.fe   = f;
        e.data = d;
        return e;
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk25);
    endtask

    task automatic send8(input logic [7:0] b);
        line8 = 1'b0;
        wait_cycles(16);
        for (int i = 0; i < 8; i++) begin
            line8 = b[i];
            wait_cycles(16);
        end
        line8 = 1'b1;
        wait_cycles(16);
    endtask

    task automatic send7(input logic [6:0] b, input logic p);
        line7 = 1'b0;
        wait_cycles(16);
        for (int i = 0; i < 7; i++) begin
            line7 = b[i];
            wait_cycles(16);
        end
        line7 = p;
        wait_cycles(16);
        line7 = 1'b1;
        wait_cycles(16);
    endtask

    task automatic pop8(output logic got, output ent_t obs);
        got = 1'b0;
        obs = '0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk25);
            if (valid8 === 1'b1) got = 1'b1;
        end
        if (got) begin
            obs = mk(brk8, pe8, fe8, {1'b0, data8});
            ready8 = 1'b1;
            @(negedge clk25);
            ready8 = 1'b0;
        end
    endtask

    task automatic pop7(output logic got, output ent_t obs);
        got = 1'b0;
        obs = '0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk25);
            if (valid7 === 1'b1) got = 1'b1;
        end
        if (got) begin
            obs = mk(brk7, pe7, fe7, {2'b00, data7});
            ready7 = 1'b1;
            @(negedge clk25);
            ready7 = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wait_cycles(3);
        n_tests++;
        if ({valid8, data8, overrun8, cts8} !== {1'b0, 8'h00, 1'b0, 1'b1}) begin
            n_fail++;
            $display("[TB] FAIL reset_dut8: got %b expected %b", {valid8, data8, overrun8, cts8}, 11'b00000000001);
        end
        n_tests++;
        if ({valid7, overrun7, cts7} !== 3'b001) begin
            n_fail++;
            $display("[TB] FAIL reset_dut7: got %b expected 001", {valid7, overrun7, cts7});
        end
        rst_n = 1'b1;
        wait_cycles(3);
        n_tests++;
        if ({cts8, cts7, valid8, valid7} !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL post_reset_cts: got %b expected 0000", {cts8, cts7, valid8, valid7});
        end
    endtask

    task automatic test_basic();
        logic got;
        ent_t obs, exp_e;
        q8.push_back(mk(1'b0, 1'b0, 1'b0, 9'h08D));
        send8(8'h8D);
        pop8(got, obs);
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("[TB] FAIL basic_timeout: got no rx_valid expected one entry");
            void'(q8.pop_front());
        end else begin
            exp_e = q8.pop_front();
            if (obs !== exp_e) begin
                n_fail++;
                $display("[TB] FAIL basic_8d: got %h expected %h", obs, exp_e);
            end
        end
    endtask

    task automatic test_parity();
        logic got;
        ent_t obs, exp_e;
        logic [6:0] d;
        d = 7'h41;
        q7.push_back(mk(1'b0, ^{d, 1'b1}, 1'b0, {2'b00, d}));
        send7(d, 1'b1);
        q7.push_back(mk(1'b0, ^{d, 1'b0}, 1'b0, {2'b00, d}));
        send7(d, 1'b0);
        for (int i = 0; i < 2; i++) begin
            pop7(got, obs);
            n_tests++;
            if (!got) begin
                n_fail++;
                $display("[TB] FAIL parity_timeout: got no rx_valid expected entry %0d", i);
                void'(q7.pop_front());
            end else begin
                exp_e = q7.pop_front();
                if (obs !== exp_e) begin
                    n_fail++;
                    $display("[TB] FAIL parity_%0d: got %h expected %h", i, obs, exp_e);
                end
            end
        end
    endtask

    task automatic test_false_start();
        logic got;
        ent_t obs, exp_e;
        line8 = 1'b0;
        wait_cycles(6);
        line8 = 1'b1;
        wait_cycles(60);
        n_tests++;
        if (valid8 !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL glitch_no_push: got rx_valid %b expected 0", valid8);
        end
        q8.push_back(mk(1'b0, 1'b0, 1'b0, 9'h055));
        send8(8'h55);
        pop8(got, obs);
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("[TB] FAIL glitch_timeout: got no rx_valid expected 0x55");
            void'(q8.pop_front());
        end else begin
            exp_e = q8.pop_front();
            if (obs !== exp_e) begin
                n_fail++;
                $display("[TB] FAIL glitch_then_55: got %h expected %h", obs, exp_e);
            end
        end
    endtask

    task automatic test_break();
        logic got;
        ent_t obs, exp_e;
        q8.push_back(mk(1'b1, 1'b0, 1'b1, 9'h000));
        line8 = 1'b0;
        wait_cycles(12 * 16);
        line8 = 1'b1;
        wait_cycles(40);
        pop8(got, obs);
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("[TB] FAIL break_timeout: got no rx_valid expected break entry");
            void'(q8.pop_front());
        end else begin
            exp_e = q8.pop_front();
            if (obs !== exp_e) begin
                n_fail++;
                $display("[TB] FAIL break_entry: got %h expected %h", obs, exp_e);
            end
        end
        wait_cycles(2);
        n_tests++;
        if (valid8 !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL break_single: got rx_valid %b expected 0", valid8);
        end
    endtask

    task automatic test_back_to_back();
        logic got;
        ent_t obs, exp_e;
        logic [7:0] b;
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom_range(1, 255));
            q8.push_back(mk(1'b0, 1'b0, 1'b0, {1'b0, b}));
            send8(b);
        end
        for (int i = 0; i < 3; i++) begin
            pop8(got, obs);
            n_tests++;
            if (!got) begin
                n_fail++;
                $display("[TB] FAIL b2b_timeout: got no rx_valid expected entry %0d", i);
                void'(q8.pop_front());
            end else begin
                exp_e = q8.pop_front();
                if (obs !== exp_e) begin
                    n_fail++;
                    $display("[TB] FAIL b2b_%0d: got %h expected %h", i, obs, exp_e);
                end
            end
        end
    endtask

    task automatic test_overrun();
        logic got;
        ent_t obs, exp_e;
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) q8.push_back(mk(1'b0, 1'b0, 1'b0, 9'(i)));
            send8(8'(i));
            if (i == 2) begin
                n_tests++;
                if (cts8 !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL cts_after_2: got %b expected 0", cts8);
                end
            end
            if (i == 3) begin
                n_tests++;
                if (cts8 !== 1'b1) begin
                    n_fail++;
                    $display("[TB] FAIL cts_after_3: got %b expected 1", cts8);
                end
            end
            if (i == 4 || i == 5) begin
                n_tests++;
                if (overrun8 !== (i == 5)) begin
                    n_fail++;
                    $display("[TB] FAIL overrun_after_%0d: got %b expected %b", i, overrun8, (i == 5));
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            pop8(got, obs);
            n_tests++;
            if (!got) begin
                n_fail++;
                $display("[TB] FAIL ovr_timeout: got no rx_valid expected entry %0d", i);
                void'(q8.pop_front());
            end else begin
                exp_e = q8.pop_front();
                if (obs !== exp_e) begin
                    n_fail++;
                    $display("[TB] FAIL ovr_pop_%0d: got %h expected %h", i, obs, exp_e);
                end
            end
        end
        wait_cycles(2);
        n_tests++;
        if ({valid8, overrun8, cts8} !== 3'b010) begin
            n_fail++;
            $display("[TB] FAIL ovr_drained: got valid/overrun/cts %b expected 010", {valid8, overrun8, cts8});
        end
        clr8 = 1'b1;
        @(negedge clk25);
        clr8 = 1'b0;
        n_tests++;
        if (overrun8 !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL overrun_clear: got %b expected 0", overrun8);
        end
    endtask

    task automatic test_reset_mid();
        logic got;
        ent_t obs, exp_e;
        logic [7:0] a;
        a = 8'hA5;
        q8.push_back(mk(1'b0, 1'b0, 1'b0, 9'h077));
        send8(8'h77);
        n_tests++;
        if (valid8 !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL pre_reset_valid: got %b expected 1", valid8);
        end
        line8 = 1'b0;
        wait_cycles(16);
        for (int i = 0; i < 3; i++) begin
            line8 = a[i];
            wait_cycles(16);
        end
        line8 = a[3];
        wait_cycles(8);
        rst_n = 1'b0;
        line8 = 1'b1;
        q8.delete();
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(40);
        n_tests++;
        if ({valid8, overrun8} !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL mid_reset_clear: got valid/overrun %b expected 00", {valid8, overrun8});
        end
        q8.push_back(mk(1'b0, 1'b0, 1'b0, 9'h03C));
        send8(8'h3C);
        pop8(got, obs);
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("[TB] FAIL mid_reset_timeout: got no rx_valid expected 0x3C");
            void'(q8.pop_front());
        end else begin
            exp_e = q8.pop_front();
            if (obs !== exp_e) begin
                n_fail++;
                $display("[TB] FAIL mid_reset_3c: got %h expected %h", obs, exp_e);
            end
        end
    endtask

    initial begin
        #4000000;
        $display("[TB] FAIL watchdog: got no finish expected bench end before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n  = 1'b0;
        line8  = 1'b1;
        line7  = 1'b1;
        ready8 = 1'b0;
        ready7 = 1'b0;
        clr8   = 1'b0;
        clr7   = 1'b0;
        test_reset();
        test_basic();
        test_parity();
        test_false_start();
        test_break();
        test_back_to_back();
        test_overrun();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
